bcd_sevenseg_scan: RTL and testbench

- Downstream display stage for the counter → bin2bcd path.
- Consumes the 12-bit packed BCD value (3 digits) and drives a time-multiplexed 3-digit common-segment seven-segment display.
- Contains a prescaler, a digit-scan FSM and a per-frame snapshot register, so the digits never tear while a frame is being shown.

---
 rtl/bcd_sevenseg_scan.sv | 126 ++++++++++++
 tb/tb_bcd_sevenseg_scan.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_sevenseg_scan.sv
// Time-multiplexed 3-digit seven-segment driver with per-frame BCD snapshot.
// Optional leading-zero blanking is enabled by defining BCD_SEVENSEG_SCAN_LZB_EN.
module bcd_sevenseg_scan #(
    parameter int unsigned TICKS_PER_DIGIT = 1000,
    parameter int unsigned PRESCALE_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        StInit,
        StDig0,
        StDig1,
        StDig2
    } state_e;

    localparam logic [PRESCALE_W-1:0] CntLast = PRESCALE_W'(TICKS_PER_DIGIT - 1);
    localparam logic [PRESCALE_W-1:0] CntOne  = PRESCALE_W'(1);

`ifdef BCD_SEVENSEG_SCAN_LZB_EN
    localparam bit LzbEn = 1'b1;
`else
    localparam bit LzbEn = 1'b0;
`endif

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [11:0]           snap_q, snap_d;
    logic                  frame_done_q, frame_done_d;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StInit;
            cnt_q        <= '0;
            snap_q       <= 12'h000;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            snap_q       <= snap_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        snap_d       = snap_q;
        frame_done_d = 1'b0;
        if (state_q == StInit) begin
            // Leaving reset captures a fresh frame unconditionally, without a pulse.
            snap_d  = bcd;
            cnt_d   = '0;
            state_d = StDig0;
        end else if (en) begin
            if (cnt_q == CntLast) begin
                cnt_d = '0;
                unique case (state_q)
                    StDig0: state_d = StDig1;
                    StDig1: state_d = StDig2;
                    default: begin
                        state_d      = StDig0;
                        snap_d       = bcd;
                        frame_done_d = 1'b1;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + CntOne;
            end
        end
    end

    always_comb begin
        logic [3:0] nib;
        logic       blank;
        an    = 3'b000;
        nib   = 4'h0;
        blank = 1'b1;
        unique case (state_q)
            StInit: ;
            StDig0: begin
                an    = 3'b001;
                nib   = snap_q[3:0];
                blank = 1'b0;
            end
            StDig1: begin
                an    = 3'b010;
                nib   = snap_q[7:4];
                blank = LzbEn && (snap_q[11:8] == 4'h0) && (snap_q[7:4] == 4'h0);
            end
            StDig2: begin
                an    = 3'b100;
                nib   = snap_q[11:8];
                blank = LzbEn && (snap_q[11:8] == 4'h0);
            end
        endcase
        seg = blank ? 7'h00 : seg7(nib);
    end

    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Scoreboard bench for bcd_sevenseg_scan: a frame-level model predicts each cycle's display.
module tb_bcd_sevenseg_scan;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [11:0] bcd = 12'h000;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        frame_done;

    bcd_sevenseg_scan #(
        .TICKS_PER_DIGIT(T),
        .PRESCALE_W     (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bcd       (bcd),
        .seg       (seg),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [6:0] seg_tab [16];

    // Model: position within the frame as a count of enabled cycles 0..3T-1.
    bit          m_active = 1'b0;
    int          m_ticks  = 0;
    logic [11:0] m_snap   = 12'h000;
    logic        m_fd     = 1'b0;

    function automatic exp_t predict();
        exp_t       e;
        int         d;
        logic [3:0] nib;
        logic [3:0] hund;
        logic [3:0] tens;
        logic [11:0] sh;
        e = '0;
        if (m_active) begin
            d    = m_ticks / T;
            sh   = m_snap >> (4 * d);
            nib  = sh[3:0];
            hund = m_snap[11:8];
            tens = m_snap[7:4];
            e.an  = 3'(1 << d);
            e.seg = seg_tab[nib];
`ifdef BCD_SEVENSEG_SCAN_LZB_EN
            if (d == 2 && hund == 4'h0) e.seg = 7'h00;
            if (d == 1 && hund == 4'h0 && tens == 4'h0) e.seg = 7'h00;
`endif
            e.fd = m_fd;
        end
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_active = 1'b0;
                m_fd     = 1'b0;
            end else if (!m_active) begin
                m_active = 1'b1;
                m_ticks  = 0;
                m_snap   = bcd;
                m_fd     = 1'b0;
            end else begin
                m_fd = 1'b0;
                if (en) begin
                    m_ticks++;
                    if (m_ticks == 3 * T) begin
                        m_ticks = 0;
                        m_snap  = bcd;
                        m_fd    = 1'b1;
                    end
                end
            end
            q.push_back(predict());
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard t=%0t: no expected entry queued", $time);
            end else begin
                e = q.pop_front();
                if (rst) e = '0;
                if (an !== e.an || seg !== e.seg || frame_done !== e.fd) begin
                    n_err++;
                    $display("FAIL scan t=%0t an=%b want %b seg=%h want %h fd=%b want %b",
                             $time, an, e.an, seg, e.seg, frame_done, e.fd);
                end
            end
        end
    end

    task automatic check_blank(input string name);
        n_vec++;
        if (an !== 3'b000 || seg !== 7'h00 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL %s t=%0t an=%b seg=%h fd=%b want 000/00/0",
                     name, $time, an, seg, frame_done);
        end
    endtask

    task automatic step(input logic e, input logic [11:0] b, input int n);
        en  = e;
        bcd = b;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Asserted 3 units after a rising edge, so deliberately not clock-aligned.
    task automatic async_reset(input string name);
        #1;
        rst = 1'b1;
        #1;
        check_blank(name);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    function automatic logic [11:0] rand_bcd();
        logic [11:0] v;
        v = 12'($urandom);
        if ($urandom_range(0, 3) != 0) begin
            v[3:0]  = 4'($urandom_range(0, 9));
            v[7:4]  = 4'($urandom_range(0, 9));
            v[11:8] = 4'($urandom_range(0, 9));
        end
        if ($urandom_range(0, 4) == 0) v[11:4] = 8'h00;
        return v;
    endfunction

    initial begin
        logic [11:0] b;
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        #1;
        check_blank("reset_state");
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        bcd = 12'h123;
        rst = 1'b0;

        step(1'b1, 12'h123, 17);
        step(1'b1, 12'h456, 2);
        step(1'b0, 12'h456, 10);
        step(1'b1, 12'h456, 20);
        step(1'b1, 12'h1A5, 24);
        step(1'b1, 12'h007, 24);

        for (int i = 0; i < 20; i++) begin
            if (an == 3'b100) break;
            step(1'b1, 12'h007, 1);
        end
        bcd = 12'h890;
        async_reset("reset_mid_scan");
        step(1'b1, 12'h890, 16);
        step(1'b0, 12'h890, 3);
        step(1'b1, 12'h000, 14);

        b = rand_bcd();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) b = rand_bcd();
            if ($urandom_range(0, 120) == 0) begin
                bcd = b;
                async_reset("reset_random");
            end
            step(($urandom_range(0, 9) < 7), b, 1);
        end

        @(negedge clk);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
